hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs1_i / id_rs2_i  in  5  source registers of the instruction in ID.
REQ-005 SHALL have ports id_rs1_used_i / id_rs2_used_i  in  1  the ID instruction reads rs1 / rs2.
REQ-006 SHALL have ports ex_rs1_i / ex_rs2_i / ex_rd_i  in  5 each  EX-stage sources and destination.
REQ-007 SHALL have ports ex_valid_i, ex_regWEn_i, ex_is_load_i  in  1 each  EX valid, EX writes rd, EX is a load.
REQ-008 SHALL have port redirect_i  in  1  branch or jump taken, resolved in EX.
REQ-009 SHALL have ports mem_rd_i  in  5, and mem_valid_i, mem_regWEn_i  in  1  MEM-stage destination and status.
REQ-010 SHALL have ports mem_req_i, mem_ready_i  in  1  data-memory access pending in MEM / access completes this cycle.
REQ-011 SHALL have ports wb_rd_i  in  5, and wb_valid_i, wb_regWEn_i  in  1  WB-stage destination and status.
REQ-012 SHALL have ports halt_req_i, resume_i  in  1  halt request (ecall/ebreak/debug) / resume.
REQ-013 SHALL have ports stall_IF_o, stall_ID_o, stall_EX_o, stall_MEM_o  out  1  hold the pipeline register feeding that stage.
REQ-014 SHALL have ports flush_ID_o, flush_EX_o, flush_WB_o  out  1  load a bubble into that stage.
REQ-015 SHALL have ports fwdA_sel_o / fwdB_sel_o  out  2  EX operand source: 00 regfile, 01 MEM ALU result, 10 WB data.
REQ-016 SHALL have ports halted_o  out  1, and stall_cnt_o, flush_cnt_o  out  CNT_W.

Function
REQ-017 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-018 SHALL define freeze = mem_req_i & ~mem_ready_i; during freeze: stall_IF/ID/EX/MEM=1, flush_WB=1, all other flush outputs 0, FSM holds its state, and redirect_i is ignored.
REQ-019 SHALL define load_use = ex_valid_i & ex_is_load_i & ex_regWEn_i & ex_rd_i!=0 & ((id_rs1_used_i & ex_rd_i==id_rs1_i) | (id_rs2_used_i & ex_rd_i==id_rs2_i)).
REQ-020 SHALL resolve the cycle with priority freeze > redirect > load_use > DRAIN/HALTED hold.
REQ-021 SHALL, on redirect without freeze, assert flush_ID=1 and flush_EX=1 with no stalls, in any state.
REQ-022 SHALL, on load_use without freeze or redirect, assert stall_IF=1, stall_ID=1, flush_EX=1, for exactly one cycle per hazard.
REQ-023 SHALL set fwdA_sel=01 when mem_valid & mem_regWEn & mem_rd!=0 & mem_rd==ex_rs1; else 10 on the same WB match; else 00 (MEM has priority); fwdB_sel likewise on ex_rs2; forwarding is combinational and independent of state.
REQ-024 SHALL move RUN->DRAIN on halt_req_i; in DRAIN and HALTED assert stall_IF=1, stall_ID=1, flush_EX=1 unless overridden by REQ-020.
REQ-025 SHALL move DRAIN->HALTED in the first cycle with ex_valid_i, mem_valid_i, wb_valid_i all 0 and no freeze.
REQ-026 SHALL move HALTED->RUN on resume_i; halted_o=1 only in HALTED; halt_req_i is ignored outside RUN; resume_i is ignored outside HALTED.
REQ-027 SHALL increment stall_cnt by 1 each cycle stall_IF_o=1 and state!=HALTED, and flush_cnt by 1 each cycle flush_ID_o=1; both wrap modulo 2^CNT_W.

Reset
REQ-028 SHALL, on reset_i, enter RUN, clear stall_cnt and flush_cnt to 0, and drive halted_o=0; reset has priority over every input, including mid-freeze or mid-DRAIN.
REQ-029 SHALL keep the stall, flush and forwarding outputs purely combinational from state and inputs, so the reset state (RUN) gives 0 on all of them in the reset cycle.

Structure
REQ-030 SHALL take the FSM state enum and the fwd_sel encodings (FWD_RF, FWD_MEM, FWD_WB) from the shared pipeline package.
REQ-031 SHALL place forwarding in one sub-module, fwd_unit, instantiated twice (operands A and B); all other logic stays flat.

Verification
REQ-032 SHALL cover: EX lw x5, ID add x6,x5,x1 (rs1 used) -> one cycle of stall_IF=stall_ID=flush_EX=1, stall_cnt 0->1.
REQ-033 SHALL cover: MEM rd=x7 and WB rd=x7 both writing, ex_rs1=7 -> fwdA_sel=01; with mem_rd=0 and wb_rd=0, ex_rs2=0 -> fwdB_sel=00.
REQ-034 SHALL cover: redirect_i together with load_use -> flush_ID=flush_EX=1, no stall, flush_cnt +1.
REQ-035 SHALL cover: mem_req_i=1, mem_ready_i=0 for 3 cycles with redirect_i=1 -> 3 freeze cycles, flush_cnt unchanged, then redirect honoured on the ready cycle.
REQ-036 SHALL cover: halt_req_i with ex/mem/wb valid draining over 3 cycles -> DRAIN 3 cycles, then halted_o=1; resume_i -> RUN next cycle.
REQ-037 SHALL cover: preload stall_cnt to 2^CNT_W-1, then one stall -> stall_cnt wraps to 0; reset_i asserted in DRAIN -> RUN with both counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared pipeline definitions for the hazard controller: the halt FSM
//   state type, the EX operand-forwarding select encodings, and a helper
//   that decides whether a later stage's result can feed an EX source.
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // EX operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result sitting in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data

    // A stage forwards to a source register when it holds a valid,
    // register-writing instruction whose destination is that source.
    // x0 is never forwarded: it always reads as zero from the regfile.
    function automatic logic fwd_hit(
        input logic       valid,
        input logic       reg_wen,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return valid && reg_wen && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// ----------------------------------------------------------------------------
// fwd_unit
//   Operand forwarding select for one EX source register. Purely
//   combinational; MEM wins over WB because it holds the younger result.
//
//   rs_i                     EX source register
//   mem_valid/regWEn/rd_i    MEM-stage instruction status and destination
//   wb_valid/regWEn/rd_i     WB-stage instruction status and destination
//   sel_o                    FWD_RF / FWD_MEM / FWD_WB
// ----------------------------------------------------------------------------
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       mem_valid_i,
    input  logic       mem_regWEn_i,
    input  logic [4:0] mem_rd_i,
    input  logic       wb_valid_i,
    input  logic       wb_regWEn_i,
    input  logic [4:0] wb_rd_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (fwd_hit(mem_valid_i, mem_regWEn_i, mem_rd_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (fwd_hit(wb_valid_i, wb_regWEn_i, wb_rd_i, rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. Resolves, in
//   priority order, data-memory freeze, EX redirect, load-use hazard and
//   halt draining, producing per-stage stall/flush controls. Also selects
//   EX operand forwarding and keeps stall/flush performance counters.
//
//   Inputs : clk_i, reset_i (sync, active-high), ID/EX/MEM/WB register
//            ids and status, redirect_i, mem_req_i/mem_ready_i,
//            halt_req_i, resume_i
//   Outputs: stall_IF/ID/EX/MEM_o, flush_ID/EX/WB_o, fwdA/fwdB_sel_o,
//            halted_o, stall_cnt_o, flush_cnt_o (CNT_W bits, wrapping)
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,

    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,

    input  logic [4:0]       ex_rs1_i,
    input  logic [4:0]       ex_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_valid_i,
    input  logic             ex_regWEn_i,
    input  logic             ex_is_load_i,
    input  logic             redirect_i,

    input  logic [4:0]       mem_rd_i,
    input  logic             mem_valid_i,
    input  logic             mem_regWEn_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,

    input  logic [4:0]       wb_rd_i,
    input  logic             wb_valid_i,
    input  logic             wb_regWEn_i,

    input  logic             halt_req_i,
    input  logic             resume_i,

    output logic             stall_IF_o,
    output logic             stall_ID_o,
    output logic             stall_EX_o,
    output logic             stall_MEM_o,
    output logic             flush_ID_o,
    output logic             flush_EX_o,
    output logic             flush_WB_o,
    output logic [1:0]       fwdA_sel_o,
    output logic [1:0]       fwdB_sel_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;
    logic rs1_dep;
    logic rs2_dep;
    logic pipe_empty;

    // The whole pipeline freezes while a data-memory access is outstanding.
    assign freeze = mem_req_i & ~mem_ready_i;

    assign rs1_dep  = id_rs1_used_i & (ex_rd_i == id_rs1_i);
    assign rs2_dep  = id_rs2_used_i & (ex_rd_i == id_rs2_i);
    assign load_use = ex_valid_i & ex_is_load_i & ex_regWEn_i
                    & (ex_rd_i != 5'd0) & (rs1_dep | rs2_dep);

    assign pipe_empty = ~ex_valid_i & ~mem_valid_i & ~wb_valid_i;

    // ------------------------------------------------------------------
    // Stall / flush resolution. The load-use bubble lasts one cycle on its
    // own: flushing EX replaces the load's consumer slot with a bubble, so
    // the following cycle no longer sees the load in EX.
    // ------------------------------------------------------------------
    always_comb begin
        stall_IF_o  = 1'b0;
        stall_ID_o  = 1'b0;
        stall_EX_o  = 1'b0;
        stall_MEM_o = 1'b0;
        flush_ID_o  = 1'b0;
        flush_EX_o  = 1'b0;
        flush_WB_o  = 1'b0;

        if (freeze) begin
            stall_IF_o  = 1'b1;
            stall_ID_o  = 1'b1;
            stall_EX_o  = 1'b1;
            stall_MEM_o = 1'b1;
            flush_WB_o  = 1'b1;
        end else if (redirect_i) begin
            flush_ID_o  = 1'b1;
            flush_EX_o  = 1'b1;
        end else if (load_use || (state_q != RUN)) begin
            stall_IF_o  = 1'b1;
            stall_ID_o  = 1'b1;
            flush_EX_o  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Halt FSM next state, counters and registered halted flag.
    // A freeze holds the FSM wherever it is.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            unique case (state_q)
                RUN:     if (halt_req_i) state_d = DRAIN;
                DRAIN:   if (pipe_empty) state_d = HALTED;
                HALTED:  if (resume_i)   state_d = RUN;
                default: state_d = RUN;
            endcase
        end

        halted_d = (state_d == HALTED);

        stall_cnt_d = stall_cnt_q;
        if (stall_IF_o && (state_q != HALTED)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flush_ID_o) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // ------------------------------------------------------------------
    // Operand forwarding, one unit per EX source.
    // ------------------------------------------------------------------
    fwd_unit u_fwd_a (
        .rs_i         (ex_rs1_i),
        .mem_valid_i  (mem_valid_i),
        .mem_regWEn_i (mem_regWEn_i),
        .mem_rd_i     (mem_rd_i),
        .wb_valid_i   (wb_valid_i),
        .wb_regWEn_i  (wb_regWEn_i),
        .wb_rd_i      (wb_rd_i),
        .sel_o        (fwdA_sel_o)
    );

    fwd_unit u_fwd_b (
        .rs_i         (ex_rs2_i),
        .mem_valid_i  (mem_valid_i),
        .mem_regWEn_i (mem_regWEn_i),
        .mem_rd_i     (mem_rd_i),
        .wb_valid_i   (wb_valid_i),
        .wb_regWEn_i  (wb_regWEn_i),
        .wb_rd_i      (wb_rd_i),
        .sel_o        (fwdB_sel_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with a small counter width so that the
//   counter wrap is reachable. A reference model checks every output each
//   cycle; literal checks in the stimulus pin the model to hand values.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MOD  = 16;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [4:0]          id_rs1_i, id_rs2_i;
    logic                id_rs1_used_i, id_rs2_used_i;
    logic [4:0]          ex_rs1_i, ex_rs2_i, ex_rd_i;
    logic                ex_valid_i, ex_regWEn_i, ex_is_load_i;
    logic                redirect_i;
    logic [4:0]          mem_rd_i;
    logic                mem_valid_i, mem_regWEn_i, mem_req_i, mem_ready_i;
    logic [4:0]          wb_rd_i;
    logic                wb_valid_i, wb_regWEn_i;
    logic                halt_req_i, resume_i;
    logic                stall_IF_o, stall_ID_o, stall_EX_o, stall_MEM_o;
    logic                flush_ID_o, flush_EX_o, flush_WB_o;
    logic [1:0]          fwdA_sel_o, fwdB_sel_o;
    logic                halted_o;
    logic [TB_CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rs1_i      (ex_rs1_i),
        .ex_rs2_i      (ex_rs2_i),
        .ex_rd_i       (ex_rd_i),
        .ex_valid_i    (ex_valid_i),
        .ex_regWEn_i   (ex_regWEn_i),
        .ex_is_load_i  (ex_is_load_i),
        .redirect_i    (redirect_i),
        .mem_rd_i      (mem_rd_i),
        .mem_valid_i   (mem_valid_i),
        .mem_regWEn_i  (mem_regWEn_i),
        .mem_req_i     (mem_req_i),
        .mem_ready_i   (mem_ready_i),
        .wb_rd_i       (wb_rd_i),
        .wb_valid_i    (wb_valid_i),
        .wb_regWEn_i   (wb_regWEn_i),
        .halt_req_i    (halt_req_i),
        .resume_i      (resume_i),
        .stall_IF_o    (stall_IF_o),
        .stall_ID_o    (stall_ID_o),
        .stall_EX_o    (stall_EX_o),
        .stall_MEM_o   (stall_MEM_o),
        .flush_ID_o    (flush_ID_o),
        .flush_EX_o    (flush_EX_o),
        .flush_WB_o    (flush_WB_o),
        .fwdA_sel_o    (fwdA_sel_o),
        .fwdB_sel_o    (fwdB_sel_o),
        .halted_o      (halted_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: mode 0=running, 1=draining, 2=halted.
    // ---------------------------------------------------------------
    int m_mode = 0;
    int m_stalls = 0;
    int m_flushes = 0;
    bit m_en = 0;

    function automatic int src_for(input logic [4:0] rs);
        if (mem_valid_i && mem_regWEn_i && mem_rd_i != 0 && mem_rd_i == rs) return 1;
        if (wb_valid_i && wb_regWEn_i && wb_rd_i != 0 && wb_rd_i == rs) return 2;
        return 0;
    endfunction

    always @(negedge clk_i) begin
        bit waiting_mem, dep;
        int e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fwb;
        waiting_mem = mem_req_i && !mem_ready_i;
        dep = ex_valid_i && ex_is_load_i && ex_regWEn_i && ex_rd_i != 0 &&
              ((id_rs1_used_i && ex_rd_i == id_rs1_i) ||
               (id_rs2_used_i && ex_rd_i == id_rs2_i));
        {e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fwb} = '0;
        if (waiting_mem) begin
            e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1; e_fwb = 1;
        end else if (redirect_i) begin
            e_fid = 1; e_fex = 1;
        end else if (dep || m_mode != 0) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
        end

        if (m_en) begin
            chk("stall_IF",  int'(stall_IF_o),  e_sif);
            chk("stall_ID",  int'(stall_ID_o),  e_sid);
            chk("stall_EX",  int'(stall_EX_o),  e_sex);
            chk("stall_MEM", int'(stall_MEM_o), e_smem);
            chk("flush_ID",  int'(flush_ID_o),  e_fid);
            chk("flush_EX",  int'(flush_EX_o),  e_fex);
            chk("flush_WB",  int'(flush_WB_o),  e_fwb);
            chk("fwdA_sel",  int'(fwdA_sel_o),  src_for(ex_rs1_i));
            chk("fwdB_sel",  int'(fwdB_sel_o),  src_for(ex_rs2_i));
            chk("halted",    int'(halted_o),    (m_mode == 2) ? 1 : 0);
            chk("stall_cnt", int'(stall_cnt_o), m_stalls);
            chk("flush_cnt", int'(flush_cnt_o), m_flushes);
        end

        if (reset_i) begin
            m_mode = 0; m_stalls = 0; m_flushes = 0;
            m_en = 1;
        end else begin
            if (e_sif == 1 && m_mode != 2) m_stalls = (m_stalls + 1) % CNT_MOD;
            if (e_fid == 1) m_flushes = (m_flushes + 1) % CNT_MOD;
            if (!waiting_mem) begin
                if (m_mode == 0 && halt_req_i) m_mode = 1;
                else if (m_mode == 1 && !ex_valid_i && !mem_valid_i && !wb_valid_i) m_mode = 2;
                else if (m_mode == 2 && resume_i) m_mode = 0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic idle();
        id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        ex_rs1_i = 0; ex_rs2_i = 0; ex_rd_i = 0;
        ex_valid_i = 0; ex_regWEn_i = 0; ex_is_load_i = 0; redirect_i = 0;
        mem_rd_i = 0; mem_valid_i = 0; mem_regWEn_i = 0;
        mem_req_i = 0; mem_ready_i = 0;
        wb_rd_i = 0; wb_valid_i = 0; wb_regWEn_i = 0;
        halt_req_i = 0; resume_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    // EX holds lw x5; ID holds add x6,x5,x1
    task automatic load_use_vec();
        ex_valid_i = 1; ex_is_load_i = 1; ex_regWEn_i = 1; ex_rd_i = 5;
        id_rs1_i = 5; id_rs1_used_i = 1; id_rs2_i = 1; id_rs2_used_i = 1;
    endtask

    initial begin
        idle();
        reset_i = 1;
        tick(); tick();
        reset_i = 0;
        settle();
        chk("rst_stall_IF",  int'(stall_IF_o), 0);
        chk("rst_flush_ID",  int'(flush_ID_o), 0);
        chk("rst_halted",    int'(halted_o), 0);
        chk("rst_stall_cnt", int'(stall_cnt_o), 0);
        chk("rst_flush_cnt", int'(flush_cnt_o), 0);

        // load-use: one bubble cycle
        tick(); load_use_vec(); settle();
        chk("lu_stall_IF", int'(stall_IF_o), 1);
        chk("lu_stall_ID", int'(stall_ID_o), 1);
        chk("lu_flush_EX", int'(flush_EX_o), 1);
        chk("lu_flush_ID", int'(flush_ID_o), 0);
        tick(); idle(); settle();
        chk("lu_after_stall_IF", int'(stall_IF_o), 0);
        chk("lu_stall_cnt", int'(stall_cnt_o), 1);

        // forwarding
        tick(); idle();
        mem_valid_i = 1; mem_regWEn_i = 1; mem_rd_i = 7;
        wb_valid_i = 1; wb_regWEn_i = 1; wb_rd_i = 7;
        ex_rs1_i = 7; ex_rs2_i = 0;
        settle();
        chk("fwdA_mem_prio", int'(fwdA_sel_o), 1);
        chk("fwdB_x0", int'(fwdB_sel_o), 0);
        tick(); mem_rd_i = 3; ex_rs2_i = 3; settle();
        chk("fwdA_wb", int'(fwdA_sel_o), 2);
        chk("fwdB_mem", int'(fwdB_sel_o), 1);
        tick(); mem_rd_i = 0; wb_rd_i = 0; ex_rs1_i = 0; ex_rs2_i = 0; settle();
        chk("fwdB_rd0", int'(fwdB_sel_o), 0);
        tick(); mem_regWEn_i = 0; mem_rd_i = 9; ex_rs1_i = 9; settle();
        chk("fwdA_nowen", int'(fwdA_sel_o), 0);

        // redirect beats load-use
        tick(); idle(); load_use_vec(); redirect_i = 1; settle();
        chk("rd_flush_ID", int'(flush_ID_o), 1);
        chk("rd_flush_EX", int'(flush_EX_o), 1);
        chk("rd_stall_IF", int'(stall_IF_o), 0);
        tick(); idle(); settle();
        chk("rd_flush_cnt", int'(flush_cnt_o), 1);
        chk("rd_stall_cnt", int'(stall_cnt_o), 1);

        // freeze masks redirect for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); mem_req_i = 1; mem_ready_i = 0; redirect_i = 1; settle();
            chk("fz_stall_MEM", int'(stall_MEM_o), 1);
            chk("fz_flush_WB", int'(flush_WB_o), 1);
            chk("fz_flush_ID", int'(flush_ID_o), 0);
            chk("fz_flush_cnt", int'(flush_cnt_o), 1);
        end
        tick(); mem_ready_i = 1; settle();
        chk("fz_ready_flush_ID", int'(flush_ID_o), 1);
        chk("fz_ready_stall_IF", int'(stall_IF_o), 0);
        tick(); idle(); settle();
        chk("fz_flush_cnt_after", int'(flush_cnt_o), 2);
        chk("fz_stall_cnt_after", int'(stall_cnt_o), 4);

        // stall counter wrap: 11 more freeze cycles reach 15, one stall wraps
        for (int i = 0; i < 11; i++) begin
            tick(); idle(); mem_req_i = 1; mem_ready_i = 0; settle();
        end
        tick(); idle(); load_use_vec(); settle();
        chk("wrap_pre", int'(stall_cnt_o), 15);
        tick(); idle(); settle();
        chk("wrap_post", int'(stall_cnt_o), 0);

        // halt with the pipeline draining over 3 cycles
        tick(); idle(); halt_req_i = 1;
        ex_valid_i = 1; mem_valid_i = 1; wb_valid_i = 1; settle();
        chk("halt_req_halted", int'(halted_o), 0);
        chk("halt_req_stall", int'(stall_IF_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); idle();
            mem_valid_i = (i < 1); wb_valid_i = (i < 2);
            settle();
            chk("drain_stall_IF", int'(stall_IF_o), 1);
            chk("drain_flush_EX", int'(flush_EX_o), 1);
            chk("drain_halted", int'(halted_o), 0);
        end
        tick(); idle(); halt_req_i = 1; settle();
        chk("halted_1", int'(halted_o), 1);
        chk("halted_stall_cnt", int'(stall_cnt_o), 3);
        tick(); idle(); resume_i = 1; settle();
        chk("halted_2", int'(halted_o), 1);
        chk("halted_stall_cnt2", int'(stall_cnt_o), 3);
        tick(); idle(); settle();
        chk("resumed_halted", int'(halted_o), 0);
        chk("resumed_stall_IF", int'(stall_IF_o), 0);

        // reset while draining
        tick(); idle(); halt_req_i = 1; ex_valid_i = 1; settle();
        tick(); idle(); ex_valid_i = 1; settle();
        chk("drain2_stall_IF", int'(stall_IF_o), 1);
        tick(); idle(); ex_valid_i = 1; reset_i = 1; settle();
        tick(); idle(); reset_i = 0; settle();
        chk("rst_drain_stall_IF", int'(stall_IF_o), 0);
        chk("rst_drain_halted", int'(halted_o), 0);
        chk("rst_drain_stall_cnt", int'(stall_cnt_o), 0);
        chk("rst_drain_flush_cnt", int'(flush_cnt_o), 0);
        tick(); idle(); settle();
        chk("rst_drain_still_run", int'(halted_o), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
